// File: rtl/fetch_stage.sv
// XM23 instruction fetch front end: issues word reads over req/gnt/rvalid, buffers returns
// in a prefetch FIFO and presents them to decode, honouring stall, redirect and sleep.

module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [15:0] NOP_INST   = 16'h4C00
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        sleep,
   input  logic        wake,
   output logic [15:0] inst,
   output logic [15:0] inst_pc,
   output logic        inst_valid,
   output logic [15:0] fetch_pc
);

   localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
   localparam logic [15:0] RESET_PC_C = RESET_PC & 16'hFFFE;

   typedef enum logic [1:0] {StIdle, StRun, StSleep} state_e;

   state_e                state_q, state_d;
   logic [15:0]           fetch_pc_q, fetch_pc_d;
   logic [15:0]           resp_pc_q, resp_pc_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         push_idx;
   logic [15:0]           ent_inst_q [FIFO_DEPTH];
   logic [15:0]           ent_inst_d [FIFO_DEPTH];
   logic [15:0]           ent_pc_q   [FIFO_DEPTH];
   logic [15:0]           ent_pc_d   [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d;
   logic                  grant, resp_accept, do_push, do_pop;
   logic [15:0]           redirect_pc;

   assign redirect_pc = branch_target & 16'hFFFE;
   // A response with nothing outstanding is a leftover from before reset and is ignored.
   assign resp_accept = imem_rvalid && (outstanding_q != '0);
   assign do_push     = resp_accept && (drop_cnt_q == '0) && !branch_taken;
   assign do_pop      = ent_vld_q[0] && !stall && !branch_taken;
   assign push_idx    = count_q - CW'(do_pop);

   // Credit check counts in-flight reads so returns can never overflow the FIFO.
   assign imem_req = (state_q == StRun) && !branch_taken &&
                     (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C);
   assign grant    = imem_req && imem_gnt;

   assign imem_addr  = fetch_pc_q;
   assign fetch_pc   = fetch_pc_q;
   assign inst       = ent_inst_q[0];
   assign inst_pc    = ent_pc_q[0];
   assign inst_valid = ent_vld_q[0];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StRun;
         StRun:   if (sleep && !branch_taken) state_d = StSleep;
         StSleep: if (wake || branch_taken) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      outstanding_d = outstanding_q + CW'(grant) - CW'(resp_accept);
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      if (branch_taken) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         drop_cnt_d = outstanding_d;
      end else begin
         if (grant) fetch_pc_d = fetch_pc_q + 16'd2;
         if (do_push) resp_pc_d = resp_pc_q + 16'd2;
         if (resp_accept && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   // Shift FIFO: entry 0 is always the head so the decode outputs come straight from flops.
   always_comb begin
      ent_inst_d = ent_inst_q;
      ent_pc_d   = ent_pc_q;
      ent_vld_d  = ent_vld_q;
      count_d    = count_q;
      if (branch_taken) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            ent_inst_d[i] = NOP_INST;
            ent_pc_d[i]   = 16'h0000;
         end
         ent_vld_d = '0;
         count_d   = '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
               ent_inst_d[i] = ent_inst_q[i+1];
               ent_pc_d[i]   = ent_pc_q[i+1];
               ent_vld_d[i]  = ent_vld_q[i+1];
            end
            ent_inst_d[FIFO_DEPTH-1] = NOP_INST;
            ent_pc_d[FIFO_DEPTH-1]   = 16'h0000;
            ent_vld_d[FIFO_DEPTH-1]  = 1'b0;
         end
         if (do_push) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
               if (CW'(i) == push_idx) begin
                  ent_inst_d[i] = imem_rdata;
                  ent_pc_d[i]   = resp_pc_q;
                  ent_vld_d[i]  = 1'b1;
               end
            end
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         fetch_pc_q    <= RESET_PC_C;
         resp_pc_q     <= RESET_PC_C;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         ent_vld_q     <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            ent_inst_q[i] <= NOP_INST;
            ent_pc_q[i]   <= 16'h0000;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         ent_vld_q     <= ent_vld_d;
         ent_inst_q    <= ent_inst_d;
         ent_pc_q      <= ent_pc_d;
      end
   end

endmodule
